ntt_result_streamer: RTL and testbench

- Downstream stage of the radix-2 NTT core.
- When the core signals completion, this block takes the read port of the coefficient BRAM and reads all N transformed coefficients in order.
- Each word gets an optional final conditional subtraction mod Q, then goes out on a valid/ready stream with index and last markers.
- It absorbs the BRAM's 1-cycle read latency and downstream backpressure without dropping or duplicating words.

---
 rtl/ntt_pkg.sv | 27 ++
 rtl/stream_fifo2.sv | 70 +++++++
 rtl/ntt_result_streamer.sv | 213 +++++++++++++++++++++
 tb/tb_ntt_result_streamer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT result streamer: default sizes, the
// streamer FSM encoding and the bit-reverse helper also used by the
// address-ROM generator.
package ntt_pkg;

    localparam int NTT_N      = 256;
    localparam int NTT_ADDR_W = 8;
    localparam int NTT_DATA_W = 32;
    localparam int NTT_Q      = 3329;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } stream_state_e;

    // Reverse the low 'width' bits of 'value'; bits above 'width' come back 0.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = 32'd0;
        for (int i = 0; i < width; i++) begin
            result[width - 1 - i] = value[i];
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO carrying {data, index, last} beats. Push and pop may occur
// in the same cycle; occupancy then stays the same and order is preserved.
module stream_fifo2 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [ADDR_W-1:0] push_index_i,
    input  logic              push_last_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [ADDR_W-1:0] head_index_o,
    output logic              head_last_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] data_q  [2];
    logic [ADDR_W-1:0] index_q [2];
    logic [1:0]        last_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;

    // Occupancy update from the push/pop combination.
    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and count; the head slot is written only after it is popped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i]  <= '0;
                index_q[i] <= '0;
            end
            last_q   <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q]  <= push_data_i;
                index_q[wr_ptr_q] <= push_index_i;
                last_q[wr_ptr_q]  <= push_last_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign valid_o      = (cnt_q != 2'd0);
    assign head_data_o  = data_q[rd_ptr_q];
    assign head_index_o = index_q[rd_ptr_q];
    assign head_last_o  = last_q[rd_ptr_q];
    assign count_o      = cnt_q;

endmodule

// File: rtl/ntt_result_streamer.sv
// Reads the N transformed coefficients out of the NTT BRAM after the core
// finishes, applies the final conditional subtraction of Q and streams them
// with index/last markers. At most two words are ever outstanding (FIFO plus
// the one in the BRAM pipeline), so backpressure never loses a word.
module ntt_result_streamer
    import ntt_pkg::*;
#(
    parameter int N          = NTT_N,
    parameter int ADDR_W     = NTT_ADDR_W,
    parameter int DATA_W     = NTT_DATA_W,
    parameter int Q          = NTT_Q,
    parameter int REDUCE     = 1,
    parameter int BITREV_OUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_index,
    output logic              m_last
);

    localparam logic [ADDR_W:0]   N_CNT    = (ADDR_W + 1)'(N);
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(N - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
    localparam logic [DATA_W-1:0] Q_W      = DATA_W'(Q);

    stream_state_e     state_q, state_d;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] cap_idx_q, cap_idx_d;
    logic              inflight_q, inflight_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic              done_q, done_d;

    logic              start_accept_s;
    logic              pop_s;
    logic              issue_s;
    logic              last_issue_s;
    logic [2:0]        occ_s;
    logic [ADDR_W:0]   next_cnt_s;
    logic [ADDR_W-1:0] addr_src_s;
    logic [31:0]       bitrev_full_s;
    logic [ADDR_W-1:0] addr_mapped_s;
    logic [DATA_W-1:0] reduced_s;

    logic              fifo_valid_s;
    logic [DATA_W-1:0] fifo_data_s;
    logic [ADDR_W-1:0] fifo_index_s;
    logic              fifo_last_s;
    logic [1:0]        fifo_cnt_s;

    // Read-issue decision: words already queued plus the one in the BRAM
    // pipeline, minus the one leaving now, must stay below two.
    always_comb begin
        start_accept_s = (state_q == ST_IDLE) && start;
        pop_s          = fifo_valid_s && m_ready;
        occ_s          = {1'b0, fifo_cnt_s} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s        = (state_q == ST_RUN) && (issue_cnt_q < N_CNT) && (occ_s < 3'd2);
        last_issue_s   = (issue_cnt_q == LAST_CNT);
        next_cnt_s     = issue_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    end

    // Address mapping: natural index, or bit-reversed so the stream comes out in natural order.
    always_comb begin
        if (start_accept_s) begin
            addr_src_s = '0;
        end else begin
            addr_src_s = next_cnt_s[ADDR_W-1:0];
        end
        bitrev_full_s = bit_reverse(32'(addr_src_s), ADDR_W);
        if (BITREV_OUT != 0) begin
            addr_mapped_s = ADDR_W'(bitrev_full_s);
        end else begin
            addr_mapped_s = addr_src_s;
        end
    end

    // Final conditional subtraction; inputs are below 2Q so one step suffices.
    always_comb begin
        if ((REDUCE != 0) && (mem_dout >= Q_W)) begin
            reduced_s = mem_dout - Q_W;
        end else begin
            reduced_s = mem_dout;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start only counts in IDLE; leave DRAIN on the last handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s && last_issue_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && fifo_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        mem_req_d = (state_d != ST_IDLE);
        done_d    = (state_q == ST_DRAIN) && pop_s && fifo_last_s;

        if (start_accept_s) begin
            issue_cnt_d = '0;
        end else if (issue_s) begin
            issue_cnt_d = next_cnt_s;
        end else begin
            issue_cnt_d = issue_cnt_q;
        end

        // The address stops at the last read instead of wrapping back to 0.
        if (start_accept_s) begin
            mem_addr_d = addr_mapped_s;
        end else if (issue_s && !last_issue_s) begin
            mem_addr_d = addr_mapped_s;
        end else begin
            mem_addr_d = mem_addr_q;
        end

        inflight_d = issue_s;
        if (issue_s) begin
            cap_idx_d = issue_cnt_q[ADDR_W-1:0];
        end else begin
            cap_idx_d = cap_idx_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt_q <= '0;
            mem_addr_q  <= '0;
            cap_idx_q   <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            mem_addr_q  <= mem_addr_d;
            cap_idx_q   <= cap_idx_d;
            inflight_q  <= inflight_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            done_q      <= done_d;
        end
    end

    stream_fifo2 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rst),
        .push_i       (inflight_q),
        .push_data_i  (reduced_s),
        .push_index_i (cap_idx_q),
        .push_last_i  (cap_idx_q == LAST_IDX),
        .pop_i        (pop_s),
        .valid_o      (fifo_valid_s),
        .head_data_o  (fifo_data_s),
        .head_index_o (fifo_index_s),
        .head_last_o  (fifo_last_s),
        .count_o      (fifo_cnt_s)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign m_valid  = fifo_valid_s;
    assign m_data   = fifo_data_s;
    assign m_index  = fifo_index_s;
    assign m_last   = fifo_valid_s && fifo_last_s;

endmodule

// File: tb/tb_ntt_result_streamer.sv
// Bench for ntt_result_streamer: two instances in lockstep, one natural
// order with reduction, one bit-reversed without reduction, each with its
// own BRAM model. Expected beats come from a reference model over the
// memory images.
module tb_ntt_result_streamer;

    localparam int          NN  = 256;
    localparam logic [31:0] QV  = 32'd3329;
    localparam int          MODE_READY  = 0;
    localparam int          MODE_STALL  = 1;
    localparam int          MODE_RANDOM = 2;
    localparam int          CYC_LIMIT   = 3000;

    typedef struct {
        int          idx;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        m_ready;

    logic        busy_a, done_a, mem_req_a, m_valid_a, m_last_a;
    logic [7:0]  mem_addr_a, m_index_a;
    logic [31:0] mem_dout_a, m_data_a;
    logic        busy_b, done_b, mem_req_b, m_valid_b, m_last_b;
    logic [7:0]  mem_addr_b, m_index_b;
    logic [31:0] mem_dout_b, m_data_b;

    logic [31:0] mem_a [NN];
    logic [31:0] mem_b [NN];
    logic [31:0] cap_a [NN];
    logic [31:0] cap_b [NN];

    vec_t red_vecs [8];
    vec_t br_vecs  [4];

    int total;
    int bad;

    ntt_result_streamer #(.REDUCE(1), .BITREV_OUT(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
        .mem_req(mem_req_a), .mem_addr(mem_addr_a), .mem_dout(mem_dout_a),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
        .m_index(m_index_a), .m_last(m_last_a)
    );

    ntt_result_streamer #(.REDUCE(0), .BITREV_OUT(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_dout(mem_dout_b),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
        .m_index(m_index_b), .m_last(m_last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models with one cycle of read latency.
    always @(posedge clk) begin
        mem_dout_a <= mem_a[mem_addr_a];
        mem_dout_b <= mem_b[mem_addr_b];
    end

    function automatic int rev8(input int k);
        int r;
        int v;
        r = 0;
        v = k;
        for (int i = 0; i < 8; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_a(input int k);
        logic [31:0] w;
        w = mem_a[k];
        return (w >= QV) ? (w - QV) : w;
    endfunction

    function automatic logic [31:0] ref_b(input int k);
        return mem_b[rev8(k)];
    endfunction

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%0d required=%0d", name, tag, act, exp);
        end
    endtask

    task automatic check_reset_values(input int tag);
        check("rst_busy_a", tag, busy_a, 1'b0);
        check("rst_done_a", tag, done_a, 1'b0);
        check("rst_memreq_a", tag, mem_req_a, 1'b0);
        check("rst_valid_a", tag, m_valid_a, 1'b0);
        check("rst_last_a", tag, m_last_a, 1'b0);
        check("rst_addr_a", tag, mem_addr_a, 32'd0);
        check("rst_data_a", tag, m_data_a, 32'd0);
        check("rst_index_a", tag, m_index_a, 32'd0);
        check("rst_valid_b", tag, m_valid_b, 1'b0);
        check("rst_addr_b", tag, mem_addr_b, 32'd0);
    endtask

    // One full stream from a start pulse; optional restart and mid-stream reset.
    task automatic run_stream(input int mode, input int restart_at, input int reset_at, input bit check_lat);
        int          beats_a, beats_b, dones_a, dones_b, done_cyc, first_valid, stall_left, post;
        bit          stall_used, hold_prev, restarted, restart_check;
        logic [31:0] hold_data;
        logic [7:0]  hold_idx;
        logic        hold_last;
        beats_a = 0; beats_b = 0; dones_a = 0; dones_b = 0;
        done_cyc = -1; first_valid = -1; stall_left = 0; post = -1;
        stall_used = 1'b0; hold_prev = 1'b0; restarted = 1'b0; restart_check = 1'b0;
        hold_data = 32'd0; hold_idx = 8'd0; hold_last = 1'b0;

        @(negedge clk);
        start   = 1'b1;
        m_ready = 1'b1;
        for (int cyc = 1; cyc <= CYC_LIMIT; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (restart_check) begin
                check("busy_after_restart", beats_a, busy_a, 1'b1);
                restart_check = 1'b0;
            end
            if (check_lat && cyc == 1) begin
                check("busy_rise", cyc, busy_a, 1'b1);
                check("memreq_rise", cyc, mem_req_a, 1'b1);
                check("first_addr_a", cyc, mem_addr_a, 32'd0);
                check("first_addr_b", cyc, mem_addr_b, 32'd0);
            end
            if (first_valid < 0 && m_valid_a) first_valid = cyc;
            if (done_a) begin
                dones_a++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_b) dones_b++;
            if (done_cyc >= 0 && post < 0) post = 4;
            if (post == 0) break;
            if (post > 0) post--;

            if (hold_prev) begin
                check("hold_valid", beats_a, m_valid_a, 1'b1);
                check("hold_data", beats_a, m_data_a, hold_data);
                check("hold_index", beats_a, m_index_a, hold_idx);
                check("hold_last", beats_a, m_last_a, hold_last);
                check("addr_ahead", beats_a, ({1'b0, mem_addr_a} <= ({1'b0, hold_idx} + 9'd2)), 1'b1);
            end

            case (mode)
                MODE_RANDOM: m_ready = 1'($urandom_range(0, 1));
                MODE_STALL: begin
                    if (!stall_used && m_valid_a && m_index_a == 8'd5) begin
                        stall_used = 1'b1;
                        stall_left = 10;
                    end
                    if (stall_left > 0) begin
                        m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
                default: m_ready = 1'b1;
            endcase

            if (m_valid_a && m_ready) begin
                if (beats_a < NN) begin
                    check("index_a", beats_a, m_index_a, beats_a);
                    check("data_a", beats_a, m_data_a, ref_a(beats_a));
                    check("last_a", beats_a, m_last_a, (beats_a == NN - 1));
                    cap_a[beats_a] = m_data_a;
                end else begin
                    check("extra_beat_a", beats_a, beats_a + 1, NN);
                end
                beats_a++;
            end
            if (m_valid_b && m_ready) begin
                if (beats_b < NN) begin
                    check("index_b", beats_b, m_index_b, beats_b);
                    check("data_b", beats_b, m_data_b, ref_b(beats_b));
                    check("last_b", beats_b, m_last_b, (beats_b == NN - 1));
                    cap_b[beats_b] = m_data_b;
                end else begin
                    check("extra_beat_b", beats_b, beats_b + 1, NN);
                end
                beats_b++;
            end
            hold_prev = m_valid_a && !m_ready;
            hold_data = m_data_a;
            hold_idx  = m_index_a;
            hold_last = m_last_a;

            if (restart_at >= 0 && !restarted && beats_a == restart_at) begin
                start         = 1'b1;
                restarted     = 1'b1;
                restart_check = 1'b1;
            end
            if (reset_at >= 0 && beats_a == reset_at) begin
                #2;
                rst = 1'b0;
                #1;
                check("async_valid_a", beats_a, m_valid_a, 1'b0);
                check("async_busy_a", beats_a, busy_a, 1'b0);
                check("async_memreq_a", beats_a, mem_req_a, 1'b0);
                check("async_valid_b", beats_a, m_valid_b, 1'b0);
                check("async_busy_b", beats_a, busy_b, 1'b0);
                return;
            end
        end

        check("beats_a", mode, beats_a, NN);
        check("beats_b", mode, beats_b, NN);
        check("done_pulses_a", mode, dones_a, 1);
        check("done_pulses_b", mode, dones_b, 1);
        check("busy_after_a", mode, busy_a, 1'b0);
        check("busy_after_b", mode, busy_b, 1'b0);
        check("memreq_after_a", mode, mem_req_a, 1'b0);
        check("valid_after_a", mode, m_valid_a, 1'b0);
        if (mode == MODE_STALL) check("stall_seen", mode, stall_used, 1'b1);
        if (check_lat) begin
            check("done_latency", mode, done_cyc, NN + 3);
            check("first_valid_latency", mode, first_valid, 3);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst     = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;

        red_vecs[0] = '{idx: 3,  word: 32'd3330, exp: 32'd1};
        red_vecs[1] = '{idx: 4,  word: 32'd3328, exp: 32'd3328};
        red_vecs[2] = '{idx: 5,  word: 32'd0,    exp: 32'd0};
        red_vecs[3] = '{idx: 10, word: 32'd3329, exp: 32'd0};
        red_vecs[4] = '{idx: 11, word: 32'd6657, exp: 32'd3328};
        red_vecs[5] = '{idx: 12, word: 32'd1,    exp: 32'd1};
        red_vecs[6] = '{idx: 13, word: 32'd6656, exp: 32'd3327};
        red_vecs[7] = '{idx: 14, word: 32'd3331, exp: 32'd2};
        br_vecs[0]  = '{idx: 1,   word: 32'd0, exp: 32'd128};
        br_vecs[1]  = '{idx: 2,   word: 32'd0, exp: 32'd64};
        br_vecs[2]  = '{idx: 255, word: 32'd0, exp: 32'd255};
        br_vecs[3]  = '{idx: 3,   word: 32'd0, exp: 32'd192};

        for (int i = 0; i < NN; i++) begin
            mem_a[i] = 32'(i);
            mem_b[i] = 32'(i);
        end
        repeat (3) @(negedge clk);
        check_reset_values(0);
        rst = 1'b1;
        @(negedge clk);

        // Natural data, always ready, latency and bit-reverse table.
        run_stream(MODE_READY, -1, -1, 1'b1);
        for (int v = 0; v < 4; v++) begin
            check("bitrev_tbl", br_vecs[v].idx, cap_b[br_vecs[v].idx], br_vecs[v].exp);
        end

        // Reduction table under a 10-cycle stall on beat 5.
        for (int i = 0; i < NN; i++) begin
            mem_a[i] = 32'(i);
            mem_b[i] = $urandom();
        end
        for (int v = 0; v < 8; v++) mem_a[red_vecs[v].idx] = red_vecs[v].word;
        run_stream(MODE_STALL, -1, -1, 1'b0);
        for (int v = 0; v < 8; v++) begin
            check("reduce_tbl", red_vecs[v].idx, cap_a[red_vecs[v].idx], red_vecs[v].exp);
        end

        // Random data, random backpressure.
        for (int i = 0; i < NN; i++) begin
            mem_a[i] = $urandom_range(0, 6657);
            mem_b[i] = $urandom();
        end
        run_stream(MODE_RANDOM, -1, -1, 1'b0);

        // Ignored restart at beat 100, asynchronous reset at beat 150.
        run_stream(MODE_READY, 100, 150, 1'b0);
        @(negedge clk);
        check_reset_values(1);
        rst = 1'b1;
        @(negedge clk);

        // Fresh stream after reset starts again at index 0.
        for (int i = 0; i < NN; i++) begin
            mem_a[i] = $urandom_range(0, 6657);
            mem_b[i] = $urandom();
        end
        run_stream(MODE_READY, -1, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
